// File: rtl/generador_sumador4_pkg.sv
// Shared definitions for the 4-bit adder stimulus generator/checker:
// FSM encodings, adder modes, LFSR geometry and the op record.
package generador_sumador4_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODO_HOLD = 2'b00,
    MODO_ADD  = 2'b01,
    MODO_SUB  = 2'b10,
    MODO_CLR  = 2'b11
  } modo_t;

  typedef struct packed {
    modo_t      modo;
    logic       rci;
    logic [3:0] a;
    logic [3:0] b;
  } op_t;

  localparam int              LFSR_W       = 16;
  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps at bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'h002D;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  localparam op_t OP_NONE  = '{modo: MODO_HOLD, rci: 1'b0, a: 4'd0, b: 4'd0};
  localparam op_t OP_CLEAR = '{modo: MODO_CLR,  rci: 1'b0, a: 4'd0, b: 4'd0};

  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic fb;
    fb = ^(s & LFSR_TAPS);
    return {fb, s[LFSR_W-1:1]};
  endfunction

  function automatic op_t op_from_lfsr(input logic [LFSR_W-1:0] l);
    op_t o;
    o.modo = modo_t'(l[9:8]);
    o.rci  = l[10];
    o.a    = l[3:0];
    o.b    = l[7:4];
    return o;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload and advance enable.
module lfsr16
  import generador_sumador4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_r;

  // LFSR register; a zero seed would lock up, so it is replaced by 1
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= seed_fix(INIT);
    end else if (load) begin
      state_r <= seed_fix(seed);
    end else if (advance) begin
      state_r <= lfsr_step(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/generador_sumador4.sv
// Pseudo-random stimulus generator and self-checker for a 4-bit adder:
// drives ops from an LFSR, models the expected sum and counts mismatches.
module generador_sumador4
  import generador_sumador4_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] N_OPS,
  output logic       ENB_O,
  output logic [1:0] MODO_O,
  output logic       RCI_O,
  output logic [3:0] A_O,
  output logic [3:0] B_O,
  input  logic [3:0] Q_I,
  input  logic       RCO_I,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] ERR_CNT,
  output logic       PASS
);

  localparam logic [LFSR_W-1:0] SEED_EFF = seed_fix(SEED);

  state_t            state_r, state_s;
  logic [7:0]        cnt_r, cnt_s;
  logic              lfsr_load_s, lfsr_adv_s, start_s;
  logic [LFSR_W-1:0] lfsr_state_s;
  op_t               op_r, nxt_op_s;
  logic              enb_r, nxt_enb_s;
  logic              busy_r, done_r, pass_r, pass_s;
  logic [7:0]        err_r, err_s;
  logic [3:0]        q_r, q_s;
  logic              c_r, c_s;
  logic              chk_r, chk_add_r, mismatch_s;

  lfsr16 #(.INIT(SEED_EFF)) u_lfsr (
    .CLK    (CLK),
    .RST    (RST),
    .load   (lfsr_load_s),
    .seed   (SEED_EFF),
    .advance(lfsr_adv_s),
    .state  (lfsr_state_s)
  );

  // Next state, op counter and the op to be presented in the next cycle
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    lfsr_load_s = 1'b0;
    lfsr_adv_s  = 1'b0;
    start_s     = 1'b0;
    nxt_op_s    = OP_NONE;
    nxt_enb_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s     = ST_CLEAR;
          cnt_s       = N_OPS;
          lfsr_load_s = 1'b1;
          start_s     = 1'b1;
          nxt_op_s    = OP_CLEAR;
          nxt_enb_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR, ST_RUN: begin
        if (cnt_r != 8'd0) begin
          state_s    = ST_RUN;
          cnt_s      = cnt_r - 8'd1;
          lfsr_adv_s = 1'b1;
          nxt_op_s   = op_from_lfsr(lfsr_state_s);
          nxt_enb_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DRAIN: state_s = ST_FIN;
      ST_FIN:   state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Reference model of the adder, advanced by the op currently on the outputs
  always_comb begin
    q_s = q_r;
    c_s = c_r;
    if (enb_r) begin
      case (op_r.modo)
        MODO_HOLD: q_s = q_r;
        MODO_ADD:  {c_s, q_s} = {1'b0, op_r.a} + {1'b0, op_r.b} + {4'd0, op_r.rci};
        MODO_SUB:  q_s = op_r.a - op_r.b;
        MODO_CLR: begin
          q_s = 4'd0;
          c_s = 1'b0;
        end
        default:   q_s = q_r;
      endcase
    end else begin
      q_s = q_r;
    end
  end

  // One mismatch per checked cycle, even if sum and carry both differ
  always_comb begin
    mismatch_s = chk_r && ((Q_I != q_r) || (chk_add_r && (RCO_I != c_r)));
    if (start_s) begin
      err_s = 8'd0;
    end else if (mismatch_s && (err_r != 8'hFF)) begin
      err_s = err_r + 8'd1;
    end else begin
      err_s = err_r;
    end
    if (start_s) begin
      pass_s = 1'b0;
    end else if (state_s == ST_FIN) begin
      pass_s = (err_s == 8'd0);
    end else begin
      pass_s = pass_r;
    end
  end

  // State, model and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      op_r      <= OP_NONE;
      enb_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
      err_r     <= 8'd0;
      q_r       <= 4'd0;
      c_r       <= 1'b0;
      chk_r     <= 1'b0;
      chk_add_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      op_r      <= nxt_op_s;
      enb_r     <= nxt_enb_s;
      busy_r    <= (state_s == ST_CLEAR) || (state_s == ST_RUN) || (state_s == ST_DRAIN);
      done_r    <= (state_s == ST_FIN);
      pass_r    <= pass_s;
      err_r     <= err_s;
      q_r       <= q_s;
      c_r       <= c_s;
      chk_r     <= enb_r;
      chk_add_r <= enb_r && (op_r.modo == MODO_ADD);
    end
  end

  assign ENB_O   = enb_r;
  assign MODO_O  = op_r.modo;
  assign RCI_O   = op_r.rci;
  assign A_O     = op_r.a;
  assign B_O     = op_r.b;
  assign BUSY    = busy_r;
  assign DONE    = done_r;
  assign PASS    = pass_r;
  assign ERR_CNT = err_r;

endmodule

// File: tb/tb_generador_sumador4.sv
// Scoreboard bench for generador_sumador4 with an ideal 4-bit adder attached.
module tb_generador_sumador4;

  localparam logic [15:0] SEED_TB = 16'hACE1;

  logic       CLK, RST, START;
  logic [7:0] N_OPS;
  logic       ENB_O, RCI_O, BUSY, DONE, PASS;
  logic [1:0] MODO_O;
  logic [3:0] A_O, B_O, Q_I;
  logic       RCO_I;
  logic [7:0] ERR_CNT;

  logic [3:0] add_q;
  logic       add_c;
  logic [1:0] qmode;  // 0 ideal, 1 tied to F, 2 inverted

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  generador_sumador4 #(.SEED(SEED_TB)) dut (
    .CLK(CLK), .RST(RST), .START(START), .N_OPS(N_OPS),
    .ENB_O(ENB_O), .MODO_O(MODO_O), .RCI_O(RCI_O), .A_O(A_O), .B_O(B_O),
    .Q_I(Q_I), .RCO_I(RCO_I), .BUSY(BUSY), .DONE(DONE),
    .ERR_CNT(ERR_CNT), .PASS(PASS)
  );

  always #5 CLK = ~CLK;

  // Ideal adder under test
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      add_q <= 4'd0;
      add_c <= 1'b0;
    end else if (ENB_O) begin
      case (MODO_O)
        2'b01:   {add_c, add_q} <= {1'b0, A_O} + {1'b0, B_O} + {4'd0, RCI_O};
        2'b10:   add_q <= A_O - B_O;
        2'b11: begin
          add_q <= 4'd0;
          add_c <= 1'b0;
        end
        default: add_q <= add_q;
      endcase
    end
  end

  assign Q_I   = (qmode == 2'd1) ? 4'hF : (qmode == 2'd2) ? ~add_q : add_q;
  assign RCO_I = add_c;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] tb_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // Push the expected op sequence and compute the expected error count
  function automatic void prepare(input logic [7:0] n, input logic [1:0] qm, output int errs);
    logic [15:0] l;
    logic [3:0]  a, b, q;
    logic [1:0]  m;
    logic        ci, c;
    l = SEED_TB;
    q = 4'd0;
    c = 1'b0;
    exp_q.push_back({2'b11, 1'b0, 4'd0, 4'd0});
    errs = (qm == 2'd2) ? 1 : ((qm == 2'd1) ? 1 : 0);
    for (int i = 0; i < int'(n); i++) begin
      a  = l[3:0];
      b  = l[7:4];
      m  = l[9:8];
      ci = l[10];
      exp_q.push_back({m, ci, a, b});
      case (m)
        2'b01:   {c, q} = {1'b0, a} + {1'b0, b} + {4'd0, ci};
        2'b10:   q = a - b;
        2'b11:   q = 4'd0;
        default: q = q;
      endcase
      if ((qm == 2'd2) || ((qm == 2'd1) && (q != 4'hF))) begin
        if (errs < 255) errs++;
      end
      l = tb_lfsr(l);
    end
  endfunction

  task automatic compare_op(input string tag);
    logic [10:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_underflow"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_op"}, {MODO_O, RCI_O, A_O, B_O}, e);
    end
  endtask

  task automatic run_test(input logic [7:0] n, input logic [1:0] qm, input bit pulse5, input string tag);
    int exp_err;
    int busy_cnt = 0;
    int done_cyc = -1;
    @(negedge CLK);
    qmode = qm;
    N_OPS = n;
    START = 1'b1;
    prepare(n, qm, exp_err);
    for (int cyc = 1; cyc <= int'(n) + 10; cyc++) begin
      @(negedge CLK);
      START = pulse5 && (cyc == 6);
      if (BUSY) busy_cnt++;
      if (ENB_O) compare_op(tag);
      if (DONE) begin
        done_cyc = cyc;
        break;
      end
    end
    check_val({tag, "_done_cycle"}, done_cyc, int'(n) + 3);
    check_val({tag, "_busy_cycles"}, busy_cnt, int'(n) + 2);
    check_val({tag, "_err_cnt"}, ERR_CNT, exp_err);
    check_val({tag, "_pass"}, PASS, (exp_err == 0) ? 1 : 0);
    check_val({tag, "_sb_left"}, exp_q.size(), 0);
    exp_q.delete();
    @(negedge CLK);
    check_val({tag, "_done_pulse"}, DONE, 0);
    check_val({tag, "_pass_held"}, PASS, (exp_err == 0) ? 1 : 0);
    check_val({tag, "_idle_busy"}, BUSY, 0);
  endtask

  task automatic reset_mid_run(input logic [7:0] n);
    int exp_err;
    int done_cnt = 0;
    @(negedge CLK);
    qmode = 2'd0;
    N_OPS = n;
    START = 1'b1;
    prepare(n, 2'd0, exp_err);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge CLK);
      START = 1'b0;
      if (ENB_O) compare_op("abort");
    end
    #2 RST = 1'b1;
    #1 check_val("abort_async_outs",
                 {ENB_O, MODO_O, RCI_O, A_O, B_O, BUSY, DONE, PASS, ERR_CNT}, 0);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge CLK);
      if (DONE) done_cnt++;
    end
    check_val("abort_no_done", done_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    CLK   = 1'b0;
    RST   = 1'b1;
    START = 1'b0;
    N_OPS = 8'd0;
    qmode = 2'd0;
    repeat (2) @(negedge CLK);
    check_val("reset_outs", {ENB_O, MODO_O, RCI_O, A_O, B_O, BUSY, DONE, PASS, ERR_CNT}, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run_test(8'd100, 2'd0, 1'b0, "ideal100");
    run_test(8'd0,   2'd0, 1'b0, "ideal0");
    run_test(8'd10,  2'd1, 1'b0, "tiedF10");
    run_test(8'd255, 2'd2, 1'b0, "inv255");
    run_test(8'd20,  2'd0, 1'b1, "start_in_run");
    reset_mid_run(8'd50);
    run_test(8'd50,  2'd0, 1'b0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
